uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, giving the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, giving the serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, giving the number of FIFO entries (power of two).
REQ-004 SHALL have port clk  input  1  as the single system clock; all logic is on the rising edge.
REQ-005 SHALL have port reset  input  1  as the asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port rx  input  1  as the asynchronous UART serial line, idle high.
REQ-007 SHALL have port empty  output  1  which is high when the FIFO holds no bytes.
REQ-008 SHALL have port pop_data  output  8  which holds the most recently popped FIFO byte.
REQ-009 SHALL have port rx_done  output  1  which is a one-clk pulse per correctly framed received byte.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer whose flops are reset to 1; all receive logic uses only the synchronized rx.
REQ-011 SHALL generate a 16x oversample tick every DIV = CLK_FREQ/(BAUD*16) clk cycles using integer division (651 at the defaults); the tick counter wraps at DIV-1.
REQ-012 SHALL implement a receiver FSM with states IDLE, START, DATA and STOP.
REQ-013 SHALL, in IDLE, move to START on synchronized rx = 0 and clear the tick count.
REQ-014 SHALL, in START, sample rx at tick 8 (mid-bit); if rx = 0 it moves to DATA, else it returns to IDLE as a glitch.
REQ-015 SHALL, in DATA, sample one bit every 16 ticks at mid-bit, LSB first, into an 8-bit shift register, and move to STOP after the 8th bit.
REQ-016 SHALL, in STOP, sample rx 16 ticks after the last data bit (mid stop bit).
REQ-017 SHALL, if that STOP sample is 1, pulse rx_done high for exactly one clk and push the byte into the FIFO in that same cycle.
REQ-018 SHALL, if that STOP sample is 0 (framing error), discard the byte with no rx_done pulse and no push.
REQ-019 SHALL return to IDLE in the same cycle as the STOP sample, so that a start bit immediately after mid-stop is detected.
REQ-020 SHALL implement the FIFO as a circular buffer with read and write pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, plus a count of 0..FIFO_DEPTH.
REQ-021 SHALL, when a push occurs while the FIFO is full, drop the incoming byte and keep the FIFO unchanged; rx_done still pulses.
REQ-022 SHALL pop internally and automatically in every cycle in which the FIFO is not empty, one byte per cycle, oldest first.
REQ-023 SHALL register pop_data on the popped byte and hold it until the next pop.
REQ-024 SHALL, on a simultaneous push and pop, perform both operations with the count unchanged.
REQ-025 SHALL derive empty as count == 0, registered.
REQ-026 SHALL have this single-byte timing: cycle N has rx_done = 1 (push); N+1 has empty = 0; N+1 performs the pop; N+2 has pop_data = byte and empty = 1.

Reset
REQ-027 SHALL, while reset = 0, asynchronously force FSM = IDLE, tick and bit counters = 0, shift register = 0, FIFO pointers and count = 0, synchronizer = 1, rx_done = 0, empty = 1 and pop_data = 0x00.
REQ-028 SHALL abort any partially received frame on reset, with no rx_done and no push; after release the receiver waits in IDLE for the next falling edge.

Verification
REQ-029 SHALL be verified with this scenario: frame 0xAA at 104166 ns/bit, stop held high -> one rx_done pulse near mid-stop; 2 clk later pop_data = 0xAA and empty = 1.
REQ-030 SHALL be verified with this scenario: back-to-back frames 0x00..0x28, each new start bit issued right after the previous rx_done -> 41 rx_done pulses; pop_data steps 0x00, 0x01 .. 0x28 in order.
REQ-031 SHALL be verified with this scenario: rx low pulse of 30 us (under half a bit) while idle -> no rx_done; pop_data and empty unchanged.
REQ-032 SHALL be verified with this scenario: frame 0x55 with stop bit driven 0 -> no rx_done and pop_data unchanged; a following good frame 0x3C then gives pop_data = 0x3C.
REQ-033 SHALL be verified with this scenario: reset asserted during data bit 4 of frame 0xF0, then released -> outputs return to their reset values at once; the next frame 0x12 gives pop_data = 0x12.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver feeding a self-draining byte FIFO
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       empty,
  output logic [7:0] pop_data,
  output logic       rx_done
);
  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state;
  logic            rx_meta, rx_sync;
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic [3:0]      tick_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_nxt;
  logic            push, pop;
  assign tick      = div_cnt == DW'(DIV - 1);
  assign push      = rx_done && (count != (AW+1)'(FIFO_DEPTH));
  assign pop       = |count;
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  // two-flop synchronizer on the serial line, idling high
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  // free-running divider producing the 16x oversample tick
  always_ff @(posedge clk or negedge reset)
    if (!reset) div_cnt <= '0;
    else        div_cnt <= tick ? '0 : div_cnt + 1'b1;
  // receive FSM: mid-bit sampling, LSB first, rx_done only on a good stop bit
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE: if (!rx_sync) begin
          state    <= START;
          tick_cnt <= '0;
        end
        START: if (tick) begin
          if (tick_cnt == 4'd7) begin
            state    <= rx_sync ? IDLE : DATA;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end else tick_cnt <= tick_cnt + 4'd1;
        end
        DATA: if (tick) begin
          if (tick_cnt == 4'd15) begin
            shreg   <= {rx_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
          tick_cnt <= tick_cnt + 4'd1;
        end
        STOP: if (tick) begin
          if (tick_cnt == 4'd15) begin
            rx_done <= rx_sync;
            state   <= IDLE;
          end
          tick_cnt <= tick_cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  // FIFO storage, written with the completed byte on rx_done when not full
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= shreg;
  // FIFO pointers and occupancy; pops every cycle the FIFO holds data
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      pop_data <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        pop_data <= mem[rd_ptr];
      end
      count <= count_nxt;
      empty <= count_nxt == '0;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives UART frames and checks pulses and popped bytes against a frame-level model
module tb_uart_rx_fifo;
  localparam int BITC = 64;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       empty, rx_done;
  logic [7:0] pop_data;
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         vectors = 0;
  int         miscompares = 0;
  int         done_cnt = 0;
  int         n0;

  uart_rx_fifo #(.CLK_FREQ(100_000_000), .BAUD(1_562_500), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .rx(rx), .empty(empty), .pop_data(pop_data), .rx_done(rx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_ok, input logic chase);
    int t;
    if (stop_ok) begin
      exp_q.push_back(b);
      last_good = b;
    end
    drive(1'b0, BITC);
    for (int i = 0; i < 8; i++) drive(b[i], BITC);
    if (!stop_ok) begin
      drive(1'b0, BITC * 3 / 4);
      rx = 1'b1;
    end else if (chase) begin
      t = 0;
      rx = 1'b1;
      while (!rx_done && t < 2 * BITC) begin
        @(negedge clk);
        t++;
      end
      check("rx_done_wait", rx_done, 1);
    end else drive(1'b1, BITC);
  endtask

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rx_done) begin
        done_cnt++;
        if (exp_q.size() == 0) check("unexpected_rx_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          @(negedge clk);
          check("rx_done_width", rx_done, 0);
          check("empty_after_push", empty, 0);
          @(negedge clk);
          check("pop_data", pop_data, e);
          check("empty_after_pop", empty, 1);
        end
      end
    end
  end

  initial begin
    logic [7:0] f;
    logic       ok;
    repeat (5) @(negedge clk);
    check("rst_rx_done", rx_done, 0);
    check("rst_empty", empty, 1);
    check("rst_pop_data", pop_data, 8'h00);
    reset = 1'b1;
    drive(1'b1, BITC);
    n0 = done_cnt;
    send(8'hAA, 1'b1, 1'b0);
    drive(1'b1, 10);
    check("aa_pulses", done_cnt - n0, 1);
    check("aa_data", pop_data, 8'hAA);
    check("aa_empty", empty, 1);
    n0 = done_cnt;
    for (int i = 0; i <= 8'h28; i++) send(8'(i), 1'b1, 1'b1);
    drive(1'b1, BITC);
    check("b2b_pulses", done_cnt - n0, 41);
    check("b2b_last", pop_data, 8'h28);
    n0 = done_cnt;
    drive(1'b0, 18);
    drive(1'b1, 2 * BITC);
    check("glitch_pulses", done_cnt - n0, 0);
    check("glitch_data", pop_data, 8'h28);
    check("glitch_empty", empty, 1);
    n0 = done_cnt;
    send(8'h55, 1'b0, 1'b0);
    drive(1'b1, 2 * BITC);
    check("frame_err_pulses", done_cnt - n0, 0);
    check("frame_err_data", pop_data, 8'h28);
    send(8'h3C, 1'b1, 1'b0);
    drive(1'b1, 10);
    check("after_err_data", pop_data, 8'h3C);
    n0 = done_cnt;
    f = 8'hF0;
    drive(1'b0, BITC);
    for (int i = 0; i < 4; i++) drive(f[i], BITC);
    drive(f[4], BITC / 2);
    reset = 1'b0;
    #1;
    check("midrst_rx_done", rx_done, 0);
    check("midrst_empty", empty, 1);
    check("midrst_pop_data", pop_data, 8'h00);
    last_good = 8'h00;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    reset = 1'b1;
    drive(1'b1, 2 * BITC);
    check("midrst_pulses", done_cnt - n0, 0);
    check("midrst_hold", pop_data, 8'h00);
    send(8'h12, 1'b1, 1'b0);
    drive(1'b1, 10);
    check("post_rst_data", pop_data, 8'h12);
    for (int k = 0; k < 16; k++) begin
      n0 = done_cnt;
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, $urandom_range(3, 20));
        ok = 1'b0;
      end else begin
        ok = $urandom_range(0, 4) != 0;
        send(8'($urandom), ok, 1'b0);
      end
      drive(1'b1, BITC + $urandom_range(0, 80));
      check("rand_pulses", done_cnt - n0, ok ? 1 : 0);
      check("rand_data", pop_data, last_good);
      check("rand_empty", empty, 1);
    end
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
